// File: rtl/sram_arbiter.sv
// Two-port sequencer for the external 512Kx8 async SRAM: the CPU has priority, the DMA port gets the remaining slots.
// Define SRAM_DMA_READ_EN to let DMA reads run real SRAM read cycles; otherwise they are acknowledged without touching the SRAM.
module sram_arbiter #(
  parameter int WRC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [18:0] cpuA,
  input  logic [7:0]  cpuD,
  output logic [7:0]  cpuQ,
  input  logic        dmaReq,
  input  logic        dmaWr,
  input  logic [18:0] dmaA,
  input  logic [7:0]  dmaD,
  output logic [7:0]  dmaQ,
  output logic        dmaAck,
  output logic        busy,
  output logic [18:0] sramA,
  output logic [7:0]  sramDo,
  input  logic [7:0]  sramDi,
  output logic        sramDoe,
  output logic        sramWe
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    DMA_ACK
  } state_t;

  state_t      state;
  logic        ownerDma;
  logic        cpuArm;
  logic [1:0]  strobeCnt;
  logic        cpuGo;

  // Level requests only start an access once per assertion; cpuArm re-arms when both strobes are low.
  assign cpuGo = cpuArm & (cpuRd | cpuWr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ownerDma  <= 1'b0;
      cpuArm    <= 1'b1;
      strobeCnt <= 2'd0;
      sramWe    <= 1'b1;
      sramDoe   <= 1'b0;
      dmaAck    <= 1'b0;
      busy      <= 1'b0;
      sramA     <= 19'd0;
      sramDo    <= 8'd0;
      cpuQ      <= 8'hFF;
      dmaQ      <= 8'hFF;
    end else begin
      dmaAck <= 1'b0;
      if (!cpuRd && !cpuWr)
        cpuArm <= 1'b1;

      case (state)
        IDLE: begin
          if (cpuGo) begin
            cpuArm   <= 1'b0;
            ownerDma <= 1'b0;
            busy     <= 1'b1;
            sramA    <= cpuA;
            sramDo   <= cpuD;
            if (cpuWr) begin
              state   <= WR_SETUP;
              sramDoe <= 1'b1;
            end else begin
              state <= RD_ADDR;
            end
          end else if (dmaReq) begin
            ownerDma <= 1'b1;
            busy     <= 1'b1;
            if (dmaWr) begin
              sramA   <= dmaA;
              sramDo  <= dmaD;
              sramDoe <= 1'b1;
              state   <= WR_SETUP;
            end else begin
`ifdef SRAM_DMA_READ_EN
              sramA <= dmaA;
              state <= RD_ADDR;
`else
              state  <= DMA_ACK;
              dmaAck <= 1'b1;
`endif
            end
          end
        end

        RD_ADDR: begin
          state <= RD_DATA;
`ifdef SRAM_DMA_READ_EN
          // DMA data is taken a clock early so it is already valid while dmaAck is high.
          if (ownerDma) begin
            dmaQ   <= sramDi;
            dmaAck <= 1'b1;
          end
`endif
        end

        RD_DATA: begin
          if (!ownerDma)
            cpuQ <= sramDi;
          state <= IDLE;
          busy  <= 1'b0;
        end

        WR_SETUP: begin
          state     <= WR_STROBE;
          sramWe    <= 1'b0;
          strobeCnt <= 2'd0;
        end

        WR_STROBE: begin
          if (strobeCnt == 2'(WRC - 1)) begin
            state  <= WR_HOLD;
            sramWe <= 1'b1;
            if (ownerDma)
              dmaAck <= 1'b1;
          end else begin
            strobeCnt <= strobeCnt + 2'd1;
          end
        end

        WR_HOLD: begin
          state   <= IDLE;
          sramDoe <= 1'b0;
          busy    <= 1'b0;
        end

        DMA_ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          sramWe  <= 1'b1;
          sramDoe <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
